// File: rtl/mem_readback_streamer.sv
// mem_readback_streamer: sweeps a BRAM address window and streams each word with its address and a running checksum
module mem_readback_streamer #(
   parameter int WID_MEM   = 18,
   parameter int DEPTH_MEM = 4096,
   parameter int ADDR_W    = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  start_addr,
   input  logic [ADDR_W:0]    num_words,
   output logic [ADDR_W-1:0]  raddr,
   input  logic [WID_MEM-1:0] rdata,
   output logic [WID_MEM-1:0] m_data,
   output logic [ADDR_W-1:0]  m_addr,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               busy,
   output logic               done,
   output logic [31:0]        checksum
);
   if (2**ADDR_W < DEPTH_MEM) begin : g_chk
      $error("ADDR_W too small for DEPTH_MEM");
   end
   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0]  addr_ptr, raddr_q;
   logic [ADDR_W-1:0]  fa [2];
   logic [WID_MEM-1:0] fd [2];
   logic [ADDR_W:0]    remaining;
   logic [1:0]         cnt;
   logic               rd, wr, inflight, issue, pop;
   always_comb begin
      pop = m_valid & m_ready;
      // occupancy counts the word still in the BRAM pipeline so a stall never overflows the FIFO
      issue = (state == SWEEP) && (remaining != '0) &&
              (3'(cnt) + 3'(inflight) < 3'd2 + 3'(pop));
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? SWEEP : IDLE;
         SWEEP:   state_nx = (remaining == '0) ? DRAIN : SWEEP;
         DRAIN:   state_nx = (!inflight && cnt == '0) ? DONE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end
   assign raddr   = issue ? addr_ptr : raddr_q;
   assign m_valid = cnt != '0;
   assign m_data  = fd[rd];
   assign m_addr  = fa[rd];
   assign busy    = (state == SWEEP) || (state == DRAIN);
   assign done    = state == DONE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         addr_ptr  <= '0;
         raddr_q   <= '0;
         remaining <= '0;
         inflight  <= 1'b0;
         cnt       <= '0;
         rd        <= 1'b0;
         wr        <= 1'b0;
         fd        <= '{default: '0};
         fa        <= '{default: '0};
         checksum  <= '0;
      end else begin
         state    <= state_nx;
         inflight <= issue;
         cnt      <= cnt + 2'(inflight) - 2'(pop);
         if (state == IDLE && start) begin
            addr_ptr  <= start_addr;
            remaining <= num_words;
            checksum  <= '0;
         end
         if (issue) begin
            raddr_q   <= addr_ptr;
            addr_ptr  <= addr_ptr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
         end
         if (inflight) begin
            fd[wr] <= rdata;
            fa[wr] <= raddr_q;
            wr     <= ~wr;
         end
         if (pop) begin
            rd       <= ~rd;
            checksum <= checksum + 32'(m_data);
         end
      end
   end
endmodule
